// File: rtl/sequence_verifier.sv
// Sequence verifier: walks the stored colour sequence for one round,
// judges each button press and reports a pass/fail verdict.
module sequence_verifier #(
  parameter int MAX_LEN = 32,
  parameter int NUM_BTN = 4,
  parameter int COLOR_W = 3,
  parameter int IDX_W   = 5,
  parameter int TIMEOUT = 200
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [MAX_LEN*COLOR_W-1:0] segment,
  input  logic [IDX_W-1:0]           round,
  input  logic                       start,
  input  logic [NUM_BTN-1:0]         btn,
  output logic                       busy,
  output logic [IDX_W-1:0]           step,
  output logic                       done,
  output logic                       pass,
  output logic [1:0]                 err_code
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_COLOR = 2'b01;
  localparam logic [1:0] ERR_MULTI = 2'b10;
  localparam logic [1:0] ERR_TIME  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_PRESS,
    WAIT_RELEASE,
    VERDICT
  } state_t;

  state_t             state;
  logic [TW-1:0]      timer;
  logic [IDX_W-1:0]   rnd;
  logic [IDX_W-1:0]   rnd_clamp;
  logic [COLOR_W-1:0] code;
  logic               no_btn;
  logic               one_hot;
  logic               hit;
  logic               expired;

  assign code    = segment[step*COLOR_W +: COLOR_W];
  assign no_btn  = (btn == '0);
  assign one_hot = $onehot(btn);
  assign expired = (TIMEOUT != 0) &&
                   (timer == TW'(TIMEOUT - 1));

  assign rnd_clamp = (32'(round) >= 32'(MAX_LEN)) ?
                     IDX_W'(MAX_LEN - 1) : round;

  // Codes at or above NUM_BTN have no button and never match.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (btn[i] && (32'(code) == i)) hit = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      step     <= '0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_code <= ERR_NONE;
      timer    <= '0;
      rnd      <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            rnd      <= rnd_clamp;
            step     <= '0;
            pass     <= 1'b0;
            err_code <= ERR_NONE;
            busy     <= 1'b1;
            state    <= ARM;
          end
        end
        ARM: begin
          if (no_btn) begin
            timer <= '0;
            state <= WAIT_PRESS;
          end
        end
        WAIT_PRESS: begin
          timer <= timer + 1'b1;
          if (!no_btn) begin
            if (!one_hot) begin
              err_code <= ERR_MULTI;
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= VERDICT;
            end else if (hit) begin
              state <= WAIT_RELEASE;
            end else begin
              err_code <= ERR_COLOR;
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= VERDICT;
            end
          end else if (expired) begin
            err_code <= ERR_TIME;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= VERDICT;
          end
        end
        WAIT_RELEASE: begin
          timer <= '0;
          if (no_btn) begin
            if (step == rnd) begin
              pass  <= 1'b1;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= VERDICT;
            end else begin
              step  <= step + 1'b1;
              state <= WAIT_PRESS;
            end
          end
        end
        VERDICT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_verifier.sv
// Bench for sequence_verifier: directed scenarios followed by
// random player scripts judged by a rule-level reference model.
module tb_sequence_verifier;

  localparam int MAX_LEN = 32;
  localparam int NUM_BTN = 4;
  localparam int COLOR_W = 3;
  localparam int IDX_W   = 5;
  localparam int TO      = 10;

  logic                       clk = 1'b0;
  logic                       reset = 1'b0;
  logic                       start = 1'b0;
  logic [MAX_LEN*COLOR_W-1:0] segment = '0;
  logic [IDX_W-1:0]           round = '0;
  logic [NUM_BTN-1:0]         btn = '0;
  logic                       busy;
  logic                       done;
  logic                       pass;
  logic [IDX_W-1:0]           step;
  logic [1:0]                 err_code;

  int seg [MAX_LEN];
  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc      = 0;
  int n_done   = 0;
  int done_cyc = 0;

  sequence_verifier #(
    .MAX_LEN(MAX_LEN),
    .NUM_BTN(NUM_BTN),
    .COLOR_W(COLOR_W),
    .IDX_W  (IDX_W),
    .TIMEOUT(TO)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .segment (segment),
    .round   (round),
    .start   (start),
    .btn     (btn),
    .busy    (busy),
    .step    (step),
    .done    (done),
    .pass    (pass),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  // done_cyc is the edge number at which done was registered.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  // Verdict for one press: 0 ok, 1 wrong colour, 2 multi, 3 timeout.
  function automatic int model(int v, int code);
    int b;
    if (v == 0) return 3;
    if ($countones(v) > 1) return 2;
    b = $clog2(v);
    return (b == code) ? 0 : 1;
  endfunction

  task automatic load_seg();
    for (int i = 0; i < MAX_LEN; i++)
      segment[i*COLOR_W +: COLOR_W] = COLOR_W'(seg[i]);
  endtask

  task automatic begin_check(int r);
    round = IDX_W'(r);
    start = 1'b1;
    tick();
    start = 1'b0;
    round = '0;
    tick();
  endtask

  task automatic press(int v, int extra);
    btn = NUM_BTN'(v);
    tick();
    if (extra != 0) begin
      btn = NUM_BTN'(v | extra);
      tick();
    end
    btn = '0;
    tick();
  endtask

  task automatic wait_done(int n0, int bound);
    int k;
    k = 0;
    while (n_done == n0 && k < bound) begin
      tick();
      k++;
    end
    chk("done_seen", n_done - n0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, r_cyc, r, e, s_end, v, k, x;

    #2 reset = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_step", step, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_code, 0);
    tick();
    tick();
    reset = 1'b0;

    for (int i = 0; i < MAX_LEN; i++) seg[i] = i % 4;
    load_seg();

    // correct full sequence, round 4
    n0 = n_done;
    begin_check(4);
    chk("full_busy", busy, 1);
    for (int s = 0; s <= 4; s++) begin
      chk("full_step", step, s);
      press(1 << seg[s], 0);
    end
    wait_done(n0, 5);
    chk("full_pass", pass, 1);
    chk("full_err", err_code, 0);
    chk("full_stepend", step, 4);
    chk("full_idle", busy, 0);
    repeat (3) tick();
    chk("full_one_done", n_done - n0, 1);

    // wrong colour at step 2; start while busy is ignored
    n0 = n_done;
    begin_check(2);
    press(1, 0);
    press(2, 0);
    round = 5'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start_ign", busy, 1);
    press(1, 0);
    wait_done(n0, 5);
    chk("wrong_pass", pass, 0);
    chk("wrong_err", err_code, 1);
    chk("wrong_step", step, 2);

    // multi-press; start during VERDICT is ignored
    n0 = n_done;
    begin_check(0);
    btn = 4'b0011;
    tick();
    chk("multi_done", done, 1);
    start = 1'b1;
    round = 5'd3;
    btn = '0;
    tick();
    start = 1'b0;
    round = '0;
    chk("multi_done_low", done, 0);
    tick();
    chk("verdict_start_ign", busy, 0);
    chk("multi_pass", pass, 0);
    chk("multi_err", err_code, 2);
    chk("multi_one_done", n_done - n0, 1);

    // timeout after a correct step 0
    n0 = n_done;
    begin_check(1);
    press(1, 0);
    r_cyc = cyc;
    wait_done(n0, 3 * TO);
    chk("tmo_latency", done_cyc - r_cyc, TO);
    chk("tmo_err", err_code, 3);
    chk("tmo_step", step, 1);
    chk("tmo_pass", pass, 0);

    // button held through start
    n0 = n_done;
    btn = 4'b0001;
    round = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("held_busy", busy, 1);
    chk("held_step", step, 0);
    chk("held_no_done", n_done - n0, 0);
    btn = '0;
    tick();
    press(1, 0);
    wait_done(n0, 5);
    chk("held_pass", pass, 1);

    // reset while at step 3
    begin_check(6);
    for (int s = 0; s < 3; s++) press(1 << seg[s], 0);
    chk("mid_step", step, 3);
    n0 = n_done;
    reset = 1'b1;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_step0", step, 0);
    chk("mid_done", done, 0);
    chk("mid_pass", pass, 0);
    chk("mid_err", err_code, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("mid_no_done", n_done - n0, 0);
    begin_check(1);
    press(1, 0);
    press(2, 0);
    wait_done(n0, 5);
    chk("fresh_pass", pass, 1);

    // random player scripts
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if ($urandom_range(0, 9) != 0)
          seg[i] = $urandom_range(0, 3);
        else
          seg[i] = $urandom_range(4, 7);
      end
      load_seg();
      r = $urandom_range(0, 7);
      e = 0;
      s_end = r;
      n0 = n_done;
      begin_check(r);
      r_cyc = cyc;
      for (int s = 0; s <= r; s++) begin
        k = $urandom_range(0, 19);
        if (k < 16) begin
          if (seg[s] < NUM_BTN) v = 1 << seg[s];
          else v = 1 << $urandom_range(0, 3);
        end else if (k < 18) begin
          v = 1 << $urandom_range(0, 3);
        end else if (k < 19) begin
          do v = $urandom_range(1, 15);
          while ($countones(v) < 2);
        end else begin
          v = 0;
        end
        e = model(v, seg[s]);
        if (e != 0) begin
          s_end = s;
          if (v != 0) press(v, 0);
          break;
        end
        x = ($urandom_range(0, 3) == 0) ?
            (1 << $urandom_range(0, 3)) : 0;
        press(v, x);
        r_cyc = cyc;
      end
      wait_done(n0, TO + 10);
      if (e == 3)
        chk("rnd_tmo_lat", done_cyc - r_cyc, TO);
      chk("rnd_pass", pass, (e == 0) ? 1 : 0);
      chk("rnd_err", err_code, e);
      chk("rnd_step", step, s_end);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
